// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V fetch front end.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo_clr.sv
// Synchronous FIFO with synchronous clear and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_clr #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr_i,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             full, empty, do_push, do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push_i && !full;
   assign do_pop  = pop_i && !empty;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Callers size their credit so a push never meets a full FIFO.
   assert property (@(posedge clk) disable iff (rst) !(push_i && !clr_i && full));

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled instruction fetch: valid/ready imem port, in-order fetch queue to decode,
// branch redirect with in-flight kill, and halt.
module riscv_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            fd_valid,
   input  logic            fd_ready,
   output logic [XLEN-1:0] fd_instr,
   output logic [XLEN-1:0] fd_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt_req
);
   localparam int unsigned CntW = cnt_width(DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CntW-1:0] outstanding_q, outstanding_d;
   logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CntW-1:0] q_count, pif_count;
   logic [CntW:0]   credit_used;
   logic            accept, live_rsp, q_pop, q_empty;
   logic [XLEN-1:0] pif_pc;
   fetch_entry_t    q_wdata, q_rdata;
   logic            unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Queue slots are reserved at issue time, so outstanding + queued bounds occupancy.
   assign credit_used    = {1'b0, outstanding_q} + {1'b0, q_count};
   assign imem_req_valid = !rst && !redirect_valid && !halt_req &&
                           (credit_used < (CntW + 1)'(DEPTH));
   assign imem_req_addr  = pc_q;
   assign accept         = imem_req_valid && imem_req_ready;

   // Responses owed to pre-redirect requests are discarded until drop_cnt drains.
   assign live_rsp = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;

   assign q_empty  = (q_count == '0);
   assign fd_valid = !q_empty;
   assign fd_pc    = q_empty ? '0 : q_rdata.pc;
   assign fd_instr = q_empty ? NOP_INSTR : q_rdata.instr;
   assign q_pop    = fd_valid && fd_ready && !redirect_valid;

   assign q_wdata.pc    = pif_pc;
   assign q_wdata.instr = imem_rsp_data;

   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q + CntW'(accept) - CntW'(imem_rsp_valid);
      drop_cnt_d    = drop_cnt_q;
      if (redirect_valid) begin
         pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
         drop_cnt_d = outstanding_q - CntW'(imem_rsp_valid);
      end else begin
         if (accept) begin
            pc_d = pc_q + XLEN'(4);
         end
         if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   sync_fifo_clr #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fetch_q (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (redirect_valid),
      .push_i  (live_rsp),
      .data_i  (q_wdata),
      .pop_i   (q_pop),
      .data_o  (q_rdata),
      .count_o (q_count)
   );

   // PCs of live in-flight requests, oldest first; tags each returning instruction.
   sync_fifo_clr #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_pc_inflight (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (redirect_valid),
      .push_i  (accept),
      .data_i  (pc_q),
      .pop_i   (live_rsp),
      .data_o  (pif_pc),
      .count_o (pif_count)
   );

   assert property (@(posedge clk) disable iff (rst)
      {1'b0, outstanding_q} == {1'b0, drop_cnt_q} + {1'b0, pif_count});

endmodule
